// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 encodings, FSM state encoding and
// the access-legality rule used when a request is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Unsupported width encoding, or a halfword/word not naturally aligned.
    function automatic logic lsu_illegal(input logic       is_st,
                                         input logic [2:0] f3,
                                         input logic [1:0] lo);
        logic bad_width;
        logic misal;
        if (is_st) bad_width = (f3 > F3_SW);
        else       bad_width = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        misal = ((f3[1:0] == 2'd1) && lo[0]) ||
                ((f3[1:0] == 2'd2) && (lo != 2'd0));
        return bad_width || misal;
    endfunction

endpackage

// File: rtl/lsu_unit_align.sv
// Byte-lane steering: store data replication and strobes, and load
// extraction with sign/zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Store lanes: replicate the datum across the word, strobe the addressed bytes.
    always_comb begin
        wdata = store_data;
        wstrb = 4'b1111;
        case (funct3[1:0])
            2'd0: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            2'd1: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: begin
                wdata = store_data;
                wstrb = 4'b1111;
            end
        endcase
    end

    // Load extract: bring the addressed byte/half down to bit 0, then extend.
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = 32'd0;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {24'd0, shifted[7:0]};
            F3_LHU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// RV32I load/store unit: one bus transaction per request, with alignment
// checking and a bus-response timeout.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; request fields sampled here
// ST_BUS  | mem_req held with stable address/data; waiting on mem_ready
// ST_RESP | done pulse with fault status; returns to ST_IDLE
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t  state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d, fault_q, fault_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] ld_q, ld_d, maddr_q, maddr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [31:0] al_wdata, al_ldata;
    logic [3:0]  al_wstrb;
    logic        timed_out;

    // In IDLE the aligner sees the incoming request; afterwards the latched one.
    assign al_f3 = (state_q == ST_IDLE) ? funct3 : f3_q;
    assign al_lo = (state_q == ST_IDLE) ? addr[1:0] : lo_q;

    lsu_align u_align (
        .funct3     (al_f3),
        .addr_lo    (al_lo),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_data  (al_ldata)
    );

    assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    // Next-state and next-output computation for the request FSM.
    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        ld_d    = ld_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    f3_d = funct3;
                    lo_d = addr[1:0];
                    if (lsu_illegal(is_store, funct3, addr[1:0])) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_BUS;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        maddr_d = {addr[31:2], 2'b00};
                        wdata_d = al_wdata;
                        wstrb_d = is_store ? al_wstrb : 4'b0000;
                    end
                end
            end
            ST_BUS: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    if (!we_q) ld_d = al_ldata;
                end else if (timed_out) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            f3_q    <= 3'd0;
            lo_q    <= 2'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            ld_q    <= 32'd0;
            maddr_q <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            req_q   <= req_d;
            we_q    <= we_d;
            ld_q    <= ld_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign load_data = ld_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Bench for lsu_unit: directed cases plus randomized transactions against a
// byte-level reference model of the load/store rules and response timing.
module tb_lsu_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, fault;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_ld = 32'd0;

    always #5 clk = ~clk;

    lsu_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction. w = wait cycles before mem_ready (-1 = never).
    // poke = pulse a second start with a different address while busy.
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd,
                           input int w, input bit poke);
        int size, off, exp_cyc, done_cyc, n_done;
        bit legal, exp_fault, seen_req;
        logic [31:0] ewd, sh, mask, eld;
        logic [3:0]  estrb;

        // reference model
        off  = int'(a[1:0]);
        size = 1 << (f3 % 4);
        if (st) legal = (f3 <= 2);
        else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        if (legal && (off % size) != 0) legal = 0;
        estrb = 4'd0;
        ewd   = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + size) estrb[i] = 1'b1;
            ewd[8*i +: 8] = sd[8*(i % size) +: 8];
        end
        sh   = rd >> (8 * off);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
        eld  = sh & mask;
        if (f3 < 2 && sh[8*size-1]) eld = eld | ~mask;
        if (!legal) begin
            exp_cyc = 1; exp_fault = 1;
        end else if (w >= 0 && w <= TMO) begin
            exp_cyc = w + 2; exp_fault = 0;
        end else begin
            exp_cyc = TMO + 2; exp_fault = 1;
        end
        if (legal && !st && !exp_fault) exp_ld = eld;

        start = 1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        mem_ready = 0;
        done_cyc = -1; n_done = 0; seen_req = 0;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            start = 0;
            mem_ready = 0;
            if (poke && cyc == 2) begin
                start = 1; addr = a ^ 32'h0000_0440; funct3 = 3'd2;
            end
            if (cyc == 1) chk("busy_c1", busy, 1);
            if (mem_req) begin
                if (!seen_req) begin
                    chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                    chk("mem_we", mem_we, st);
                    chk("mem_wstrb", mem_wstrb, st ? estrb : 4'd0);
                    if (st) chk("mem_wdata", mem_wdata, ewd);
                end else begin
                    chk("mem_addr_hold", mem_addr, {a[31:2], 2'b00});
                end
                seen_req = 1;
                if (w >= 0 && cyc - 1 == w) begin
                    mem_ready = 1; mem_rdata = rd;
                end else begin
                    mem_rdata = $urandom;
                end
            end
            if (done) begin
                done_cyc = cyc; n_done++;
                chk("fault", fault, exp_fault);
                chk("load_data", load_data, exp_ld);
            end
        end
        start = 0; mem_ready = 0;
        chk("done_cycle", done_cyc, exp_cyc);
        chk("req_seen", seen_req, legal);
        @(posedge clk); #1;
        if (done) n_done++;
        chk("done_count", n_done, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        reset = 1; start = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
        mem_ready = 0; mem_rdata = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ld", load_data, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        reset = 0;
        @(posedge clk); #1;

        // store byte lanes
        run_txn(1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0, 0, 0);
        run_txn(1, 3'd1, 32'h202, 32'h1234_BEEF, 32'h0, 1, 0);
        run_txn(1, 3'd2, 32'h300, 32'hCAFE_F00D, 32'h0, 0, 0);
        // load extension
        run_txn(0, 3'd0, 32'h1, 32'h0, 32'h80FF_7F01, 0, 0);
        run_txn(0, 3'd0, 32'h2, 32'h0, 32'h80FF_7F01, 0, 0);
        run_txn(0, 3'd5, 32'h2, 32'h0, 32'h80FF_7F01, 0, 0);
        run_txn(0, 3'd1, 32'h2, 32'h0, 32'h80FF_7F01, 0, 0);
        run_txn(0, 3'd2, 32'h0, 32'h0, 32'h80FF_7F01, 0, 0);
        // illegal / misaligned: load_data must hold
        run_txn(0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0);
        run_txn(1, 3'd1, 32'h101, 32'h5555, 32'h0, 0, 0);
        run_txn(0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0);
        // waits and timeout
        run_txn(0, 3'd4, 32'h13, 32'h0, 32'h1122_3344, 3, 0);
        run_txn(0, 3'd2, 32'h40, 32'h0, 32'hDEAD_BEEF, -1, 0);
        run_txn(0, 3'd2, 32'h44, 32'h0, 32'h0BAD_F00D, 15, 0);
        run_txn(0, 3'd2, 32'h48, 32'h0, 32'h600D_CAFE, 16, 0);
        run_txn(1, 3'd2, 32'h4C, 32'h1111_2222, 32'h0, 17, 0);
        // start while busy is ignored
        run_txn(0, 3'd1, 32'h82, 32'h0, 32'h7FFF_0000, 2, 1);

        // reset while in BUS
        start = 1; is_store = 0; funct3 = 3'd2; addr = 32'h200;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        chk("bus_req", mem_req, 1);
        #2 reset = 1;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ld", load_data, 0);
        exp_ld = 32'd0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("arst_done", done, 0);
        end
        reset = 0;
        @(posedge clk); #1;
        run_txn(0, 3'd0, 32'h203, 32'h0, 32'h9A00_0000, 1, 0);

        // randomized
        for (int k = 0; k < 60; k++) begin
            int w;
            int sel;
            sel = int'($urandom_range(0, 9));
            w = (sel < 7) ? int'($urandom_range(0, 4)) :
                (sel == 7) ? int'($urandom_range(14, 18)) : -1;
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    $urandom, $urandom, w, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store unit of the RV32I core. It sits directly downstream of the ALU stage: it consumes the effective address (the ALU's `addr_alu_out`), `funct3` and `rs2`, and runs one transaction on a 32-bit word-addressed data bus. It returns sign- or zero-extended load data to writeback and flags misaligned accesses, illegal widths and bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum number of cycles the unit waits for `mem_ready` before faulting; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request strobe; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `funct3`  in  3  access width/sign (RV32I load/store encoding)
- `addr`  in  32  effective byte address
- `store_data`  in  32  rs2 value for stores
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle completion pulse
- `fault`  out  1  valid with `done`; 1 = access not performed or not completed
- `load_data`  out  32  extended load result
- `mem_req`  out  1  bus request
- `mem_we`  out  1  bus write enable
- `mem_addr`  out  32  word address: `{addr[31:2],2'b00}`
- `mem_wdata`  out  32  lane-replicated store data
- `mem_wstrb`  out  4  byte strobes (0 for loads)
- `mem_ready`  in  1  bus accept/complete, single cycle
- `mem_rdata`  in  32  read word, valid when `mem_ready`=1

## Operation
- States: IDLE, BUS, RESP.
- IDLE: when `start`=1, latch `is_store`, `funct3`, `addr` and `store_data`.
  - Illegal access → RESP with fault pending.
  - Otherwise → BUS.
- Illegal access:
  - Load with `funct3` in {3,6,7}; store with `funct3` ≥ 3.
  - Halfword with `addr[0]`=1; word with `addr[1:0]`≠0.
  - No bus request is issued for an illegal access.
- BUS:
  - `mem_req`=1, with address, strobes and data held stable.
  - When `mem_ready`=1: capture the extracted load data (loads only) → RESP, fault=0.
  - When the timeout counter reaches `TIMEOUT`: → RESP, fault=1.
- RESP: `done`=1 for one cycle, `fault` valid → IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- Store lanes:
  - SB: `wdata={4{b}}`, `wstrb=4'b0001<<addr[1:0]`.
  - SH: `wdata={2{h}}`, `wstrb=4'b0011<<{addr[1],1'b0}`.
  - SW: `wstrb=4'b1111`.
- Load extract: `rdata>>(8*addr[1:0])`, then:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- `load_data` updates only on a successful load. It holds across stores and faults.

## Timing
- Reset values:
  - State IDLE; all outputs 0, including `load_data`.
  - Timeout counter 0.
- Reset takes effect asynchronously in any state: `mem_req` drops immediately and the in-flight access is abandoned, with no `done`.
- Legal access, `start` in cycle 0:
  - `mem_req` is registered and asserted in cycle 1.
  - With `mem_ready` in cycle 1, `done` comes in cycle 2.
  - Minimum latency is 2; each wait cycle adds 1.
- Illegal access, `start` in cycle 0: `done`=1 and `fault`=1 in cycle 1.
- Timeout counter:
  - Cleared on entry to BUS; increments each BUS cycle with `mem_ready`=0.
  - Faults on the cycle the count equals `TIMEOUT`, which gives `TIMEOUT` wait cycles.
  - If `mem_ready` and the timeout coincide, `mem_ready` wins and fault=0.
- `busy` is high from cycle 1 through the RESP cycle.
- The next `start` is accepted in the cycle after RESP.
- `mem_*` outputs are registered/stable while `mem_req`=1 and are don't-care otherwise.

## Structure
- Shared core header/package holds:
  - funct3 constants: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
  - State encoding for IDLE/BUS/RESP.
- Sub-module `lsu_align`, combinational:
  - Store lane replication and strobe generation.
  - Load byte/half extraction and extension.
  - Shared with the future misaligned-trap logic.

## Test plan
- Store: SB, `addr`=0x103, `store_data`=0x000000A5, `mem_ready` in cycle 1 → `mem_addr`=0x100, `wstrb`=4'b1000, `wdata`=0xA5A5A5A5; `done` in cycle 2, fault=0.
- Load extension: `mem_rdata`=0x80FF7F01.
  - LB @0x1 → `load_data`=0x0000007F.
  - LB @0x2 → 0xFFFFFFFF.
  - LHU @0x2 → 0x000080FF.
  - LH @0x2 → 0xFFFF80FF.
  - LW @0x0 → 0x80FF7F01.
- Misalign/illegal: LW @0x102, SH @0x101 and load `funct3`=3 → `done`+fault in cycle 1; `mem_req` never asserted; `load_data` unchanged.
- Wait/timeout (`TIMEOUT`=16):
  - `mem_ready` after 3 wait cycles → `done` at cycle 5.
  - `mem_ready` never asserted → fault `done` after 16 wait cycles.
  - Re-run with `mem_ready` asserted on the 16th wait cycle → fault=0.
- Reset while in BUS → `mem_req` low immediately, no `done`; a fresh `start` afterwards completes normally.
- `start` pulsed while busy with different `addr` → ignored; exactly one `done`, for the original access.
